xgmii_tx_framer: RTL and testbench

XGMII_TX_FRAMER -- requirements
Module: xgmii_tx_framer

---
 rtl/xgmii_tx_framer.sv | 246 ++++++++++++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// xgmii_tx_framer
//
// Converts frame words from a first-word-fall-through FIFO into a 64-bit XGMII
// transmit stream. Each frame is sent as a start/preamble word, then the data
// words, then a terminate (0xFD) character. After the terminate there are at
// least IFG_WORDS all-idle words. If the FIFO runs dry in the middle of a frame,
// one error word is sent and the rest of that frame is dropped.
//
// Optional feature: define XGMII_TX_FCS_EN to append an IEEE 802.3 CRC-32 FCS
// after the last data byte. Without it, the upstream logic supplies the FCS.
//
// Ports
//   xgmii_clk     156.25 MHz clock; all logic runs on the rising edge
//   sys_rst_n     asynchronous active-low reset
//   fifo_dout     FIFO word: [63:0] data (byte 0 in [7:0]),
//                 [66:64] valid bytes - 1, [67] eof, [71:68] reserved
//   fifo_empty    high when fifo_dout is not valid
//   fifo_rd_en    pops the current FIFO word
//   xgmii_txd     XGMII transmit data, lane 0 in [7:0]
//   xgmii_txc     XGMII transmit control, one bit per lane
//   frame_cnt     frames ended with a terminate character (wraps)
//   underrun_cnt  frames aborted because of FIFO underrun (wraps)
// -----------------------------------------------------------------------------
module xgmii_tx_framer #(
    parameter int IFG_WORDS = 1
) (
    input  logic        xgmii_clk,
    input  logic        sys_rst_n,
    input  logic [71:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [31:0] frame_cnt,
    output logic [15:0] underrun_cnt
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_TAIL     = 3'd3;
    localparam logic [2:0] ST_ABORT    = 3'd4;
    localparam logic [2:0] ST_IFG      = 3'd5;

    localparam logic [63:0] IDLE_WORD     = 64'h0707070707070707;
    localparam logic [63:0] PREAMBLE_WORD = 64'hD5555555555555FB;
    localparam logic [63:0] ERROR_WORD    = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [3:0]  IFG_LOAD      = 4'(IFG_WORDS);

`ifdef XGMII_TX_FCS_EN
    localparam logic [3:0] FCS_BYTES = 4'd4;

    // Reflected CRC-32 (poly 0xEDB88320) over the first n bytes of a word.
    function automatic logic [31:0] crc_bytes(input logic [31:0] crc_in,
                                              input logic [63:0] data,
                                              input logic [3:0]  n);
        logic [31:0] c;
        c = crc_in;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < n) begin
                c = c ^ {24'd0, data[b*8 +: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_word;
`else
    localparam logic [3:0] FCS_BYTES = 4'd0;
`endif

    logic [2:0]  state_q, state_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic [63:0] tail_txd_q, tail_txd_d;
    logic [7:0]  tail_txc_q, tail_txc_d;
    logic [3:0]  ifg_cnt_q, ifg_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    logic         eof;
    logic [3:0]   valid_bytes;
    logic [3:0]   term_pos;
    logic [127:0] payload;
    logic [127:0] term_txd;
    logic [15:0]  term_txc;
    logic         unused_rsvd;

    assign unused_rsvd = ^fifo_dout[71:68];

    // Non-eof words always carry 8 bytes; their valid-count field is ignored.
    assign eof         = fifo_dout[67];
    assign valid_bytes = eof ? ({1'b0, fifo_dout[66:64]} + 4'd1) : 4'd8;
    assign term_pos    = valid_bytes + FCS_BYTES;

`ifdef XGMII_TX_FCS_EN
    assign crc_word = crc_bytes(crc_q, fifo_dout[63:0], valid_bytes);
`endif

    // The eof word and the optional TAIL word are built as one 16-lane stream:
    // data bytes, then FCS bytes, then 0xFD, then 0x07 fill. The lower 8 lanes
    // go out with the eof word. The upper 8 lanes are kept for TAIL.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        payload = {64'd0, fifo_dout[63:0]} & ~({128{1'b1}} << {valid_bytes, 3'b000});
`ifdef XGMII_TX_FCS_EN
        payload = payload | ({96'd0, ~crc_word} << {valid_bytes, 3'b000});
`endif
        term_txd = '0;
        term_txc = '0;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) < term_pos) begin
                term_txd[i*8 +: 8] = payload[i*8 +: 8];
                term_txc[i]        = 1'b0;
            end else if (4'(i) == term_pos) begin
                term_txd[i*8 +: 8] = 8'hFD;
                term_txc[i]        = 1'b1;
            end else begin
                term_txd[i*8 +: 8] = 8'h07;
                term_txc[i]        = 1'b1;
            end
        end
    end

    // Output words are registered. The value loaded in a given state appears
    // on the XGMII pins in the following cycle. So a word popped in DATA is on
    // the bus exactly one cycle later.
    always_comb begin
        state_d        = state_q;
        txd_d          = IDLE_WORD;
        txc_d          = 8'hFF;
        tail_txd_d     = tail_txd_q;
        tail_txc_d     = tail_txc_q;
        ifg_cnt_d      = ifg_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        underrun_cnt_d = underrun_cnt_q;
        fifo_rd_en     = 1'b0;
`ifdef XGMII_TX_FCS_EN
        crc_d          = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                txd_d   = PREAMBLE_WORD;
                txc_d   = 8'h01;
                state_d = ST_DATA;
`ifdef XGMII_TX_FCS_EN
                crc_d   = 32'hFFFFFFFF;
`endif
            end
            ST_DATA: begin
                if (fifo_empty) begin
                    txd_d          = ERROR_WORD;
                    txc_d          = 8'hFF;
                    underrun_cnt_d = underrun_cnt_q + 16'd1;
                    state_d        = ST_ABORT;
                end else begin
                    fifo_rd_en = 1'b1;
`ifdef XGMII_TX_FCS_EN
                    crc_d      = crc_word;
`endif
                    if (eof) begin
                        txd_d      = term_txd[63:0];
                        txc_d      = term_txc[7:0];
                        tail_txd_d = term_txd[127:64];
                        tail_txc_d = term_txc[15:8];
                        if (!term_pos[3]) begin
                            frame_cnt_d = frame_cnt_q + 32'd1;
                            ifg_cnt_d   = IFG_LOAD;
                            state_d     = ST_IFG;
                        end else begin
                            state_d = ST_TAIL;
                        end
                    end else begin
                        txd_d = fifo_dout[63:0];
                        txc_d = 8'h00;
                    end
                end
            end
            ST_TAIL: begin
                txd_d       = tail_txd_q;
                txc_d       = tail_txc_q;
                frame_cnt_d = frame_cnt_q + 32'd1;
                ifg_cnt_d   = IFG_LOAD;
                state_d     = ST_IFG;
            end
            ST_ABORT: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    if (eof) begin
                        ifg_cnt_d = IFG_LOAD;
                        state_d   = ST_IFG;
                    end
                end
            end
            ST_IFG: begin
                if (ifg_cnt_q <= 4'd1) state_d = ST_IDLE;
                else                   ifg_cnt_d = ifg_cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all registers, including the tail word, have a reset value, so a mid-frame reset leaves nothing stale.
    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= ST_IDLE;
            txd_q          <= IDLE_WORD;
            txc_q          <= 8'hFF;
            tail_txd_q     <= IDLE_WORD;
            tail_txc_q     <= 8'hFF;
            ifg_cnt_q      <= 4'd0;
            frame_cnt_q    <= 32'd0;
            underrun_cnt_q <= 16'd0;
`ifdef XGMII_TX_FCS_EN
            crc_q          <= 32'hFFFFFFFF;
`endif
        end else begin
            // NOTE: non-blocking assignments let all flops sample their pre-edge values together.
            state_q        <= state_d;
            txd_q          <= txd_d;
            txc_q          <= txc_d;
            tail_txd_q     <= tail_txd_d;
            tail_txc_q     <= tail_txc_d;
            ifg_cnt_q      <= ifg_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
`ifdef XGMII_TX_FCS_EN
            crc_q          <= crc_d;
`endif
        end
    end

    assign xgmii_txd    = txd_q;
    assign xgmii_txc    = txc_q;
    assign frame_cnt    = frame_cnt_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_xgmii_tx_framer
//
// Drives xgmii_tx_framer from a queue-based FWFT FIFO model. Every non-idle
// XGMII word is compared against a queue of expected words. Expected words are
// pushed at the same time as the stimulus. A monitor also checks that the
// IFG_WORDS words after each terminate are idle.
// -----------------------------------------------------------------------------
module tb_xgmii_tx_framer;

    localparam int IFG_WORDS = 2;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

    logic        xgmii_clk;
    logic        sys_rst_n;
    logic [71:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [31:0] frame_cnt;
    logic [15:0] underrun_cnt;

    xgmii_tx_framer #(.IFG_WORDS(IFG_WORDS)) dut (
        .xgmii_clk    (xgmii_clk),
        .sys_rst_n    (sys_rst_n),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .xgmii_txd    (xgmii_txd),
        .xgmii_txc    (xgmii_txc),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial xgmii_clk = 1'b0;
    always #5 xgmii_clk = ~xgmii_clk;

    // FWFT FIFO model: a word is popped when rd_en was high at the edge.
    logic [71:0] fq[$];
    logic        pop_now;
    initial begin
        fifo_dout  = 72'd0;
        fifo_empty = 1'b1;
    end
    always begin
        @(posedge xgmii_clk);
        pop_now = fifo_rd_en;
        #2;
        if (pop_now && fq.size() > 0) void'(fq.pop_front());
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() > 0) ? fq[0] : 72'd0;
    end

    // Scoreboard monitor.
    logic [71:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          gap    = 0;
    logic [71:0] act_w, exp_w;

    function automatic bit has_term(input logic [63:0] d, input logic [7:0] c);
        bit t;
        t = 1'b0;
        for (int i = 0; i < 8; i++) if (c[i] && d[i*8 +: 8] == 8'hFD) t = 1'b1;
        return t;
    endfunction

    always @(negedge xgmii_clk) begin
        if (sys_rst_n && mon_en) begin
            act_w = {xgmii_txc, xgmii_txd};
            if (fifo_rd_en) check("rd_en_while_empty", 72'(fifo_empty), 72'd0);
            if (gap > 0) begin
                check("ifg_idle", act_w, {8'hFF, IDLE_W});
                gap--;
            end
            if (act_w != {8'hFF, IDLE_W}) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", act_w, {8'hFF, IDLE_W});
                end else begin
                    exp_w = exp_q.pop_front();
                    check("xgmii_word", act_w, exp_w);
                end
                if (has_term(xgmii_txd, xgmii_txc)) gap = IFG_WORDS;
            end
        end
    end

    task automatic tick();
        @(negedge xgmii_clk);
    endtask

    task automatic push(input logic [63:0] d, input logic [2:0] vm1, input logic eof, input logic [3:0] rsv);
        fq.push_back({rsv, eof, vm1, d});
    endtask

    task automatic expect_w(input logic [63:0] d, input logic [7:0] c);
        exp_q.push_back({c, d});
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((fq.size() != 0 || exp_q.size() != 0) && cyc < 400) begin
            tick();
            cyc++;
        end
        check({name, "_drain"}, {8'd0, 32'(fq.size()), 32'(exp_q.size())}, 72'd0);
        repeat (IFG_WORDS + 4) tick();
    endtask

`ifdef XGMII_TX_FCS_EN
    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] fc_before;
        logic [71:0] w;
`ifdef XGMII_TX_FCS_EN
        logic [31:0] crc;
`endif
        sys_rst_n = 1'b0;
        repeat (3) tick();
        check("rst_word", {xgmii_txc, xgmii_txd}, {8'hFF, IDLE_W});
        check("rst_counters", {8'd0, frame_cnt, 16'd0, underrun_cnt}, 72'd0);
        check("rst_rd_en", 72'(fifo_rd_en), 72'd0);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;

        // Empty FIFO: idle on every cycle, no reads.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("empty_idle_word", {xgmii_txc, xgmii_txd}, {8'hFF, IDLE_W});
            check("empty_rd_en", 72'(fifo_rd_en), 72'd0);
        end

`ifndef XGMII_TX_FCS_EN
        // Two-word frame, 4 valid bytes in the eof word.
        expect_w(PRE_W, 8'h01);
        expect_w(64'h1122334455667788, 8'h00);
        expect_w(64'h070707FD00000000, 8'hF0);
        push(64'h1122334455667788, 3'd5, 1'b0, 4'hA);
        push(64'hAABBCCDD00000000, 3'd3, 1'b1, 4'h0);
        drain("frame_a");
        check("frame_a_cnt", 72'(frame_cnt), 72'd1);

        // Full eof word: terminate goes into a separate TAIL word.
        expect_w(PRE_W, 8'h01);
        expect_w(64'h0123456789ABCDEF, 8'h00);
        expect_w(64'h07070707070707FD, 8'hFF);
        push(64'h0123456789ABCDEF, 3'd7, 1'b1, 4'h5);
        drain("frame_b");
        check("frame_b_cnt", 72'(frame_cnt), 72'd2);

        // One valid byte in the eof word.
        expect_w(PRE_W, 8'h01);
        expect_w(64'hCAFEBABEDEADBEEF, 8'h00);
        expect_w(64'h070707070707FD88, 8'hFE);
        push(64'hCAFEBABEDEADBEEF, 3'd0, 1'b0, 4'hF);
        push(64'hFFEEDDCCBBAA9988, 3'd0, 1'b1, 4'h0);
        drain("frame_c");

        // Seven valid bytes: terminate in lane 7.
        expect_w(PRE_W, 8'h01);
        expect_w(64'hFD23456789ABCDEF, 8'h80);
        push(64'h0123456789ABCDEF, 3'd6, 1'b1, 4'h0);
        drain("frame_d");
        check("frame_d_cnt", 72'(frame_cnt), 72'd4);
`else
        // 60 zero bytes: FCS in lanes 4-7 of the eof word, then FD in TAIL.
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) crc = crc_ref(crc, 8'h00);
        expect_w(PRE_W, 8'h01);
        for (int i = 0; i < 7; i++) begin
            expect_w(64'd0, 8'h00);
            push(64'd0, 3'd7, 1'b0, 4'h0);
        end
        expect_w({~crc, 32'd0}, 8'h00);
        expect_w(64'h07070707070707FD, 8'hFF);
        push(64'd0, 3'd3, 1'b1, 4'h0);
        drain("fcs_frame");
        check("fcs_frame_cnt", 72'(frame_cnt), 72'd1);
`endif

        // Underrun after the 3rd of 6 words.
        fc_before = frame_cnt;
        expect_w(PRE_W, 8'h01);
        expect_w(64'h1111111111111111, 8'h00);
        expect_w(64'h2222222222222222, 8'h00);
        expect_w(64'h3333333333333333, 8'h00);
        expect_w(ERR_W, 8'hFF);
        push(64'h1111111111111111, 3'd7, 1'b0, 4'h0);
        push(64'h2222222222222222, 3'd7, 1'b0, 4'h0);
        push(64'h3333333333333333, 3'd7, 1'b0, 4'h0);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("abort_words_seen", 72'(exp_q.size()), 72'd0);
        check("abort_underrun_cnt", 72'(underrun_cnt), 72'd1);
        repeat (5) tick();
        push(64'h4444444444444444, 3'd7, 1'b0, 4'h0);
        push(64'h5555555555555555, 3'd7, 1'b0, 4'h0);
        push(64'h6666666666666666, 3'd2, 1'b1, 4'h0);
        drain("abort_discard");
        check("abort_frame_cnt", 72'(frame_cnt), 72'(fc_before));
        check("abort_underrun_final", 72'(underrun_cnt), 72'd1);

        // Reset pulse in the middle of DATA.
        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) push({8{8'hA0 + 8'(i)}}, 3'd7, 1'b0, 4'h0);
        push(64'h0F0E0D0C0B0A0908, 3'd7, 1'b1, 4'h0);
        cyc = 0;
        while (!(xgmii_txc == 8'h01 && xgmii_txd == PRE_W) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("rst_mid_preamble_seen", {xgmii_txc, xgmii_txd}, {8'h01, PRE_W});
        tick();
        tick();
        #1 sys_rst_n = 1'b0;
        #1;
        check("rst_mid_word", {xgmii_txc, xgmii_txd}, {8'hFF, IDLE_W});
        check("rst_mid_counters", {8'd0, frame_cnt, 16'd0, underrun_cnt}, 72'd0);
        check("rst_mid_rd_en", 72'(fifo_rd_en), 72'd0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        exp_q.delete();
        check("rst_mid_leftover", 72'(fq.size() != 0), 72'd1);
        // Leftover FIFO words form a new frame starting with a preamble.
        expect_w(PRE_W, 8'h01);
`ifdef XGMII_TX_FCS_EN
        crc = 32'hFFFFFFFF;
`endif
        for (int i = 0; i < fq.size(); i++) begin
            w = fq[i];
            expect_w(w[63:0], 8'h00);
`ifdef XGMII_TX_FCS_EN
            for (int b = 0; b < 8; b++) crc = crc_ref(crc, w[b*8 +: 8]);
            if (w[67]) expect_w({24'h070707, 8'hFD, ~crc}, 8'hF0);
`else
            if (w[67]) expect_w(64'h07070707070707FD, 8'hFF);
`endif
        end
        gap    = 0;
        mon_en = 1'b1;
        drain("rst_mid_restart");
        check("rst_mid_frame_cnt", 72'(frame_cnt), 72'd1);
        check("rst_mid_underrun_cnt", 72'(underrun_cnt), 72'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
